// File: rtl/imm_extend_pipe.sv
// LEGv8 immediate extractor/extender for the decode stage, with a registered
// valid/ready output stage backed by a single skid entry.
module imm_extend_pipe #(
    parameter int OUT_W    = 64,
    parameter int SHIFT_BR = 1,
    parameter int INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [2:0]         in_fmt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_imm,
    output logic               out_err
);

    generate
        if (OUT_W < 32 || OUT_W > 64) begin : g_bad_out_w
            $error("imm_extend_pipe: OUT_W must be within 32..64");
        end
        if (INSTR_W != 32) begin : g_bad_instr_w
            $error("imm_extend_pipe: INSTR_W must be 32");
        end
    endgenerate

    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_D  = 3'd1;
    localparam logic [2:0] FMT_CB = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_IW = 3'd4;

    // Bit 0 doubles as "M holds an entry", bit 1 as "S holds an entry".
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } occ_e;

    occ_e             state_r;
    occ_e             state_s;
    logic [OUT_W-1:0] m_imm_r;
    logic             m_err_r;
    logic [OUT_W-1:0] s_imm_r;
    logic             s_err_r;
    logic [64:0]      ext_s;
    logic [OUT_W-1:0] new_imm_s;
    logic             new_err_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             m_load_new_s;
    logic             m_load_skid_s;
    logic             m_clear_s;
    logic             s_load_s;
    logic             s_clear_s;
    logic             unused_s;

    // Returns {err, imm64}; everything is formed at 64 bits and truncated later.
    function automatic logic [64:0] ext_imm(input logic [31:0] instr, input logic [2:0] fmt);
        logic [63:0] wide;
        logic        err;
        wide = 64'd0;
        err  = 1'b0;
        case (fmt)
            FMT_I:  wide = {52'd0, instr[21:10]};
            FMT_D:  wide = {{55{instr[20]}}, instr[20:12]};
            FMT_CB: begin
                wide = {{45{instr[23]}}, instr[23:5]};
                if (SHIFT_BR != 0) wide = {wide[61:0], 2'b00};
                else               wide = wide;
            end
            FMT_B:  begin
                wide = {{38{instr[25]}}, instr[25:0]};
                if (SHIFT_BR != 0) wide = {wide[61:0], 2'b00};
                else               wide = wide;
            end
            FMT_IW: wide = {48'd0, instr[20:5]} << {instr[22:21], 4'b0000};
            default: begin
                wide = 64'd0;
                err  = 1'b1;
            end
        endcase
        return {err, wide};
    endfunction

    assign ext_s     = ext_imm(in_instr[31:0], in_fmt);
    assign new_imm_s = ext_s[OUT_W-1:0];
    assign new_err_s = ext_s[64];
    assign unused_s  = ^{in_instr[INSTR_W-1:26], ext_s[64:OUT_W]};

    assign in_ready   = ~state_r[1];
    assign out_valid  = state_r[0];
    assign out_imm    = m_imm_r;
    assign out_err    = m_err_r;
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid & out_ready;

    // Occupancy next-state and register load steering.
    always_comb begin
        state_s       = state_r;
        m_load_new_s  = 1'b0;
        m_load_skid_s = 1'b0;
        m_clear_s     = 1'b0;
        s_load_s      = 1'b0;
        s_clear_s     = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    state_s      = ST_ONE;
                    m_load_new_s = 1'b1;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    m_load_new_s = 1'b1;
                end else if (in_xfer_s) begin
                    state_s  = ST_FULL;
                    s_load_s = 1'b1;
                end else if (out_xfer_s) begin
                    state_s   = ST_EMPTY;
                    m_clear_s = 1'b1;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_xfer_s) begin
                    state_s       = ST_ONE;
                    m_load_skid_s = 1'b1;
                    s_clear_s     = 1'b1;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s   = ST_EMPTY;
                m_clear_s = 1'b1;
                s_clear_s = 1'b1;
            end
        endcase
    end

    // State and entry registers; M is zeroed when empty so outputs gate to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
            m_imm_r <= {OUT_W{1'b0}};
            m_err_r <= 1'b0;
            s_imm_r <= {OUT_W{1'b0}};
            s_err_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (m_load_new_s) begin
                m_imm_r <= new_imm_s;
                m_err_r <= new_err_s;
            end else if (m_load_skid_s) begin
                m_imm_r <= s_imm_r;
                m_err_r <= s_err_r;
            end else if (m_clear_s) begin
                m_imm_r <= {OUT_W{1'b0}};
                m_err_r <= 1'b0;
            end
            if (s_load_s) begin
                s_imm_r <= new_imm_s;
                s_err_r <= new_err_s;
            end else if (s_clear_s) begin
                s_imm_r <= {OUT_W{1'b0}};
                s_err_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: fixed vectors, backpressure/reset sequences and
// random traffic checked against a queue-based reference model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic        out_err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [63:0] imm;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        err;
    } vec_t;

    exp_t        q[$];
    bit          prev_stall;
    logic [63:0] prev_imm;
    logic        prev_err;

    imm_extend_pipe #(.OUT_W(64), .SHIFT_BR(1), .INSTR_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_fmt(in_fmt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference: field values as integers, sign handled by subtracting 2^n.
    function automatic exp_t ref_ext(input logic [31:0] ins, input logic [2:0] f);
        exp_t   e;
        longint x;
        longint s;
        x = longint'({32'd0, ins});
        e.err = 1'b0;
        case (f)
            3'd0: e.imm = 64'((x >> 10) % 4096);
            3'd1: begin
                s = (x >> 12) % 512;
                if (s >= 256) s = s - 512;
                e.imm = 64'(s);
            end
            3'd2: begin
                s = (x >> 5) % (longint'(1) << 19);
                if (s >= (longint'(1) << 18)) s = s - (longint'(1) << 19);
                e.imm = 64'(s * 4);
            end
            3'd3: begin
                s = x % (longint'(1) << 26);
                if (s >= (longint'(1) << 25)) s = s - (longint'(1) << 26);
                e.imm = 64'(s * 4);
            end
            3'd4: e.imm = 64'(((x >> 5) % 65536) * (longint'(1) << (16 * ((x >> 21) % 4))));
            default: begin
                e.imm = 64'd0;
                e.err = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Called at a negedge: checks current outputs, drives next inputs, advances one cycle.
    task automatic step_w(input bit ivld, input bit ordy, input logic [31:0] ins, input logic [2:0] f);
        bit in_x;
        bit out_x;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_imm", out_imm, q[0].imm);
            chk("out_err", 64'(out_err), 64'(q[0].err));
        end else begin
            chk("out_imm_gated", out_imm, 64'd0);
            chk("out_err_gated", 64'(out_err), 64'd0);
        end
        if (prev_stall) begin
            chk("stall_imm", out_imm, prev_imm);
            chk("stall_err", 64'(out_err), 64'(prev_err));
        end
        in_valid  = ivld;
        out_ready = ordy;
        in_instr  = ins;
        in_fmt    = f;
        in_x  = ivld && (q.size() < 2);
        out_x = (q.size() > 0) && ordy;
        prev_stall = (q.size() > 0) && !ordy;
        if (q.size() > 0) begin
            prev_imm = q[0].imm;
            prev_err = q[0].err;
        end
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back(ref_ext(ins, f));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input bit ivld, input bit ordy);
        step_w(ivld, ordy, $urandom, 3'($urandom_range(0, 7)));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h001FC000;
        in_fmt   = 3'd1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        prev_stall = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h001FC000, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[1] = '{32'h00FFFFE0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[2] = '{32'h00000001, 3'd3, 64'h0000_0000_0000_0004, 1'b0};
        vecs[3] = '{32'h003FFC00, 3'd0, 64'h0000_0000_0000_0FFF, 1'b0};
        vecs[4] = '{32'h0057DDE0, 3'd4, 64'h0000_BEEF_0000_0000, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 3'd6, 64'h0000_0000_0000_0000, 1'b1};
        vecs[6] = '{32'h000FF000, 3'd1, 64'h0000_0000_0000_00FF, 1'b0};
        vecs[7] = '{32'h02000000, 3'd3, 64'hFFFF_FFFF_F800_0000, 1'b0};
        vecs[8] = '{32'h00624680, 3'd4, 64'h1234_0000_0000_0000, 1'b0};
        vecs[9] = '{32'h12345678, 3'd7, 64'h0000_0000_0000_0000, 1'b1};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_fmt = 3'd0; prev_stall = 1'b0;
        prev_imm = 64'd0; prev_err = 1'b0;
        @(negedge clk);
        do_reset();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_imm", out_imm, 64'd0);

        // Fixed vectors, one word each, read back on the next cycle.
        foreach (vecs[i]) begin
            step_w(1'b1, 1'b1, vecs[i].instr, vecs[i].fmt);
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_imm", out_imm, vecs[i].imm);
            chk("vec_err", 64'(out_err), 64'(vecs[i].err));
            step_w(1'b0, 1'b1, 32'd0, 3'd0);
        end

        // Backpressure: A then B with downstream stalled, then release.
        step_w(1'b1, 1'b0, vecs[0].instr, vecs[0].fmt);
        step_w(1'b1, 1'b0, vecs[2].instr, vecs[2].fmt);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_a", out_imm, vecs[0].imm);
        step_w(1'b1, 1'b0, 32'h003FFC00, 3'd0);
        step_w(1'b0, 1'b0, 32'd0, 3'd0);
        chk("bp_still_a", out_imm, vecs[0].imm);
        step_w(1'b0, 1'b1, 32'd0, 3'd0);
        chk("bp_then_b", out_imm, vecs[2].imm);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        step_w(1'b0, 1'b1, 32'd0, 3'd0);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Streaming: 16 back-to-back words.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        // Reset while FULL discards both entries.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("full_before_reset", 64'(in_ready), 64'd0);
        do_reset();
        chk("rst_full_valid", 64'(out_valid), 64'd0);
        chk("rst_full_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'(i % 2));

        // Random traffic.
        for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
